gen2_cmd_decoder: RTL and testbench

- Consumes the serial bit stream from the Gen2 PIE receiver: bit data, bit strobe, preamble flag and end-of-command indication.
- Identifies the EPC Class 1 Gen 2 command opcode and counts bits against the per-command length.
- Checks CRC5 for Query and CRC16 for the long commands.
- Presents a decoded command code, a payload window and status to the tag controller FSM for one cycle.

---
 rtl/gen2_cmd_pkg.sv | 88 ++++++++
 rtl/gen2_cmd_decoder_crc16.sv | 28 ++
 rtl/gen2_cmd_decoder.sv | 157 +++++++++++++++
 tb/tb_gen2_cmd_decoder.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gen2_cmd_pkg.sv
// Shared types and constants for the Gen2 command decoder: command codes, FSM states,
// per-command bit lengths, CRC presets/polynomials/residues and the opcode prefix decoder.
package gen2_cmd_pkg;

  typedef enum logic [3:0] {
    CMD_NONE     = 4'd0,
    CMD_QUERYREP = 4'd1,
    CMD_ACK      = 4'd2,
    CMD_QUERY    = 4'd3,
    CMD_QUERYADJ = 4'd4,
    CMD_SELECT   = 4'd5,
    CMD_NAK      = 4'd6,
    CMD_REQRN    = 4'd7,
    CMD_READ     = 4'd8,
    CMD_WRITE    = 4'd9,
    CMD_UNKNOWN  = 4'd15
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_OPCODE   = 2'd1,
    ST_PAYLOAD  = 2'd2,
    ST_WAIT_EOP = 2'd3
  } state_e;

  localparam logic [7:0] LEN_VAR      = 8'd0;
  localparam logic [7:0] LEN_QUERYREP = 8'd4;
  localparam logic [7:0] LEN_ACK      = 8'd18;
  localparam logic [7:0] LEN_QUERY    = 8'd22;
  localparam logic [7:0] LEN_QUERYADJ = 8'd9;
  localparam logic [7:0] LEN_NAK      = 8'd8;
  localparam logic [7:0] LEN_REQRN    = 8'd40;
  localparam logic [7:0] VAR_MIN_LEN  = 8'd24;

  localparam logic [4:0]  CRC5_PRESET   = 5'b01001;
  localparam logic [4:0]  CRC5_POLY     = 5'b01001;
  localparam logic [4:0]  CRC5_RESIDUE  = 5'b00000;
  localparam logic [15:0] CRC16_PRESET  = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY    = 16'h1021;
  localparam logic [15:0] CRC16_RESIDUE = 16'h1D0F;

  // LEN_VAR marks the eop-terminated commands
  function automatic logic [7:0] cmd_len(input cmd_e c);
    case (c)
      CMD_QUERYREP: return LEN_QUERYREP;
      CMD_ACK:      return LEN_ACK;
      CMD_QUERY:    return LEN_QUERY;
      CMD_QUERYADJ: return LEN_QUERYADJ;
      CMD_NAK:      return LEN_NAK;
      CMD_REQRN:    return LEN_REQRN;
      default:      return LEN_VAR;
    endcase
  endfunction

  function automatic logic uses_crc16(input cmd_e c);
    return (c == CMD_SELECT) || (c == CMD_REQRN) || (c == CMD_READ) || (c == CMD_WRITE);
  endfunction

  // b holds the newest bits (newest in bit 0), n the bit count including the newest bit
  function automatic cmd_e decode_opcode(input logic [7:0] b, input logic [3:0] n);
    cmd_e c;
    c = CMD_NONE;
    case (n)
      4'd2: if (!b[1]) c = b[0] ? CMD_ACK : CMD_QUERYREP;
      4'd4: begin
        case (b[3:0])
          4'b1000: c = CMD_QUERY;
          4'b1001: c = CMD_QUERYADJ;
          4'b1010: c = CMD_SELECT;
          4'b1100: c = CMD_NONE;
          default: c = CMD_UNKNOWN;
        endcase
      end
      4'd8: begin
        case (b)
          8'hC0:   c = CMD_NAK;
          8'hC1:   c = CMD_REQRN;
          8'hC2:   c = CMD_READ;
          8'hC3:   c = CMD_WRITE;
          default: c = CMD_UNKNOWN;
        endcase
      end
      default: c = CMD_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/gen2_cmd_decoder_crc16.sv
// Bit-serial CRC16 (poly 0x1021, MSB-first); preset wins over shift; one bit per enabled cycle.
// Result is registered: crc reflects all bits shifted up to the previous clock edge.
module crc16_serial
  import gen2_cmd_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        preset,
  input  logic        shift_en,
  input  logic        din,
  output logic [15:0] crc
);

  logic [15:0] r_crc;
  logic        w_fb;

  assign w_fb = r_crc[15] ^ din;
  assign crc  = r_crc;

  always_ff @(posedge clk) begin
    if (reset || preset) begin
      r_crc <= CRC16_PRESET;
    end else if (shift_en) begin
      r_crc <= {r_crc[14:0], 1'b0} ^ (w_fb ? CRC16_POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/gen2_cmd_decoder.sv
// Gen2 command decoder: opcode decode, bit counting, CRC5/CRC16 check from the PIE bit stream.
// cmd_valid/cmd_err pulse the cycle after the deciding event; no backpressure, every bit is consumed.
module gen2_cmd_decoder
  import gen2_cmd_pkg::*;
#(
  parameter int PAYLOAD_W = 32,
  parameter int CNT_W     = 9
)
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bitin,
  input  logic                 bitclk,
  input  logic                 preamble,
  input  logic                 eop,
  output logic                 cmd_valid,
  output logic [3:0]           cmd_code,
  output logic                 crc_ok,
  output logic                 cmd_err,
  output logic [PAYLOAD_W-1:0] payload,
  output logic [CNT_W-1:0]     bitcount
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                 r_bitclk_d, r_preamble_d, r_eop_d;
  logic                 w_bit_ev, w_sof_ev, w_eop_ev;
  state_e               r_state, w_state_nxt;
  cmd_e                 r_cmd_code, w_code_nxt, w_dec, w_cmd_cur;
  logic [PAYLOAD_W-1:0] r_payload, w_pay_nxt;
  logic [CNT_W-1:0]     r_bitcount, w_cnt_nxt;
  logic [4:0]           r_crc5;
  logic                 w_crc5_fb;
  logic [15:0]          w_crc16;
  logic                 r_cmd_valid, r_cmd_err, r_eop_pend;
  logic                 w_valid_nxt, w_err_nxt, w_pend_nxt, w_shift;
  logic                 w_rx, w_eop_now, w_crc_good;

  assign w_bit_ev = bitclk & ~r_bitclk_d;
  assign w_sof_ev = preamble & ~r_preamble_d;
  assign w_eop_ev = eop & ~r_eop_d;

  assign w_rx      = (r_state == ST_OPCODE) || (r_state == ST_PAYLOAD);
  // an eop arriving with a bit is deferred one cycle so the decision sees that bit
  assign w_eop_now = r_eop_pend | (w_eop_ev & ~(w_bit_ev & w_rx));
  assign w_pay_nxt = {r_payload[PAYLOAD_W-2:0], bitin};
  assign w_cnt_nxt = (r_bitcount == CNT_MAX) ? r_bitcount : r_bitcount + 1'b1;
  assign w_dec     = decode_opcode(w_pay_nxt[7:0], w_cnt_nxt[3:0]);
  assign w_cmd_cur = (r_state == ST_OPCODE) ? w_dec : r_cmd_code;
  assign w_crc5_fb = r_crc5[4] ^ bitin;

  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_cmd_code;
    w_shift     = 1'b0;
    w_valid_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    w_pend_nxt  = 1'b0;
    if (w_sof_ev) begin
      w_code_nxt  = CMD_NONE;
      w_state_nxt = ST_OPCODE;
    end else if (w_eop_now && (r_state != ST_IDLE)) begin
      w_state_nxt = ST_IDLE;
      if (r_state == ST_OPCODE) begin
        w_err_nxt = 1'b1;
      end else if (r_state == ST_PAYLOAD) begin
        if ((cmd_len(r_cmd_code) != LEN_VAR) || (r_bitcount < CNT_W'(VAR_MIN_LEN)))
          w_err_nxt = 1'b1;
        else
          w_valid_nxt = 1'b1;
      end
    end else if (w_bit_ev && w_rx) begin
      w_shift    = 1'b1;
      w_pend_nxt = w_eop_ev;
      if (w_cmd_cur == CMD_UNKNOWN) begin
        w_err_nxt   = 1'b1;
        w_code_nxt  = CMD_UNKNOWN;
        w_state_nxt = ST_WAIT_EOP;
      end else if (w_cmd_cur != CMD_NONE) begin
        w_code_nxt  = w_cmd_cur;
        w_state_nxt = ST_PAYLOAD;
        if ((cmd_len(w_cmd_cur) != LEN_VAR) && (w_cnt_nxt == CNT_W'(cmd_len(w_cmd_cur)))) begin
          w_valid_nxt = 1'b1;
          w_state_nxt = ST_WAIT_EOP;
        end else if (w_cnt_nxt == CNT_MAX) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_WAIT_EOP;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cmd_code  <= CMD_NONE;
      r_cmd_valid <= 1'b0;
      r_cmd_err   <= 1'b0;
      r_eop_pend  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_code  <= w_code_nxt;
      r_cmd_valid <= w_valid_nxt;
      r_cmd_err   <= w_err_nxt;
      r_eop_pend  <= w_pend_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bitclk_d   <= 1'b0;
      r_preamble_d <= 1'b0;
      r_eop_d      <= 1'b0;
      r_payload    <= '0;
      r_bitcount   <= '0;
      r_crc5       <= CRC5_PRESET;
    end else begin
      r_bitclk_d   <= bitclk;
      r_preamble_d <= preamble;
      r_eop_d      <= eop;
      if (w_sof_ev) begin
        r_payload  <= '0;
        r_bitcount <= '0;
        r_crc5     <= CRC5_PRESET;
      end else if (w_shift) begin
        r_payload  <= w_pay_nxt;
        r_bitcount <= w_cnt_nxt;
        r_crc5     <= {r_crc5[3:0], 1'b0} ^ (w_crc5_fb ? CRC5_POLY : 5'd0);
      end
    end
  end

  crc16_serial u_crc16 (
    .clk      (clk),
    .reset    (reset),
    .preset   (w_sof_ev),
    .shift_en (w_shift),
    .din      (bitin),
    .crc      (w_crc16)
  );

  always_comb begin
    w_crc_good = 1'b1;
    if (r_cmd_code == CMD_QUERY)
      w_crc_good = (r_crc5 == CRC5_RESIDUE);
    else if (uses_crc16(r_cmd_code))
      w_crc_good = (w_crc16 == CRC16_RESIDUE);
  end

  assign cmd_valid = r_cmd_valid;
  assign cmd_err   = r_cmd_err;
  assign cmd_code  = r_cmd_code;
  assign crc_ok    = r_cmd_valid & w_crc_good;
  assign payload   = r_payload;
  assign bitcount  = r_bitcount;

endmodule

// File: tb/tb_gen2_cmd_decoder.sv
// Scoreboard bench for gen2_cmd_decoder: frames are built as bit queues, expected pulses
// are queued before each frame is sent and compared when cmd_valid/cmd_err fire.
module tb_gen2_cmd_decoder;

  localparam int PW = 32;
  localparam int CW = 9;

  logic          clk      = 1'b0;
  logic          reset    = 1'b1;
  logic          bitin    = 1'b0;
  logic          bitclk   = 1'b0;
  logic          preamble = 1'b0;
  logic          eop      = 1'b0;
  logic          cmd_valid, crc_ok, cmd_err;
  logic [3:0]    cmd_code;
  logic [PW-1:0] payload;
  logic [CW-1:0] bitcount;

  gen2_cmd_decoder #(.PAYLOAD_W(PW), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bitin     (bitin),
    .bitclk    (bitclk),
    .preamble  (preamble),
    .eop       (eop),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .crc_ok    (crc_ok),
    .cmd_err   (cmd_err),
    .payload   (payload),
    .bitcount  (bitcount)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            err;
    logic [3:0]    code;
    bit            crc;
    int            cnt;
    logic [PW-1:0] pay;
    int            lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic fbits[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   mark   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && (cmd_valid || cmd_err)) begin
      if (sb.size() == 0) begin
        check_eq("spurious_pulse", 64'({cmd_valid, cmd_err}), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("pulse_kind", 64'({cmd_valid, cmd_err}), mon_e.err ? 64'd1 : 64'd2);
        check_eq("cmd_code", 64'(cmd_code), 64'(mon_e.code));
        if (!mon_e.err) check_eq("crc_ok", 64'(crc_ok), 64'(mon_e.crc));
        check_eq("bitcount", 64'(bitcount), 64'(mon_e.cnt));
        check_eq("payload", 64'(payload), 64'(mon_e.pay));
        check_eq("latency", 64'(cyc - mark), 64'(mon_e.lat));
      end
    end
  end

  task automatic put(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) fbits.push_back(v[i]);
  endtask

  function automatic logic [4:0] model_crc5();
    logic [4:0] c = 5'b01001;
    logic       fb;
    foreach (fbits[i]) begin
      fb = c[4] ^ fbits[i];
      c  = {c[3:0], 1'b0};
      if (fb) c = c ^ 5'b01001;
    end
    return c;
  endfunction

  function automatic logic [15:0] model_crc16();
    logic [15:0] c = 16'hFFFF;
    logic        fb;
    foreach (fbits[i]) begin
      fb = c[15] ^ fbits[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return ~c;
  endfunction

  function automatic logic [PW-1:0] model_pay();
    logic [PW-1:0] p = '0;
    foreach (fbits[i]) p = {p[PW-2:0], fbits[i]};
    return p;
  endfunction

  task automatic expect_pulse(input bit err, input logic [3:0] code, input bit crc,
                              input int cnt, input int lat);
    exp_t e;
    e.err  = err;
    e.code = code;
    e.crc  = crc;
    e.cnt  = cnt;
    e.pay  = model_pay();
    e.lat  = lat;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_frame();
    fbits.delete();
    @(negedge clk) preamble = 1'b1;
    @(negedge clk) preamble = 1'b0;
  endtask

  task automatic send_bit(input logic b, input logic with_eop);
    @(negedge clk);
    bitin  = b;
    bitclk = 1'b1;
    eop    = with_eop;
    mark   = cyc;
    @(negedge clk);
    bitclk = 1'b0;
    eop    = 1'b0;
  endtask

  task automatic send_frame(input logic eop_last);
    foreach (fbits[i]) send_bit(fbits[i], eop_last && (i == fbits.size() - 1));
  endtask

  task automatic send_eop();
    @(negedge clk);
    eop  = 1'b1;
    mark = cyc;
    @(negedge clk);
    eop  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_valid", 64'(cmd_valid), 64'd0);
    check_eq("rst_err", 64'(cmd_err), 64'd0);
    check_eq("rst_code", 64'(cmd_code), 64'd0);
    check_eq("rst_crc_ok", 64'(crc_ok), 64'd0);
    check_eq("rst_payload", 64'(payload), 64'd0);
    check_eq("rst_bitcount", 64'(bitcount), 64'd0);

    // QueryRep
    start_frame();
    put(64'h1, 4);
    expect_pulse(1'b0, 4'd1, 1'b1, 4, 1);
    send_frame(1'b0);
    send_eop();
    idle(3);

    // ACK with RN16
    start_frame();
    put(64'h1, 2);
    put(64'hBEEF, 16);
    expect_pulse(1'b0, 4'd2, 1'b1, 18, 1);
    send_frame(1'b0);
    send_eop();
    idle(3);

    // Query, correct CRC5
    start_frame();
    put(64'h8, 4);
    put(64'h0, 13);
    put(64'(model_crc5()), 5);
    expect_pulse(1'b0, 4'd3, 1'b1, 22, 1);
    send_frame(1'b0);
    send_eop();
    idle(3);

    // Query with bit 10 corrupted
    start_frame();
    put(64'h8, 4);
    put(64'h0, 13);
    put(64'(model_crc5()), 5);
    fbits[10] = ~fbits[10];
    expect_pulse(1'b0, 4'd3, 1'b0, 22, 1);
    send_frame(1'b0);
    send_eop();
    idle(3);

    // QueryAdj and NAK
    start_frame();
    put(64'h9, 4);
    put(64'h15, 5);
    expect_pulse(1'b0, 4'd4, 1'b1, 9, 1);
    send_frame(1'b0);
    send_eop();
    idle(3);
    start_frame();
    put(64'hC0, 8);
    expect_pulse(1'b0, 4'd6, 1'b1, 8, 1);
    send_frame(1'b0);
    send_eop();
    idle(3);

    // Req_RN with CRC16, then eop must produce nothing further
    start_frame();
    put(64'hC1, 8);
    put(64'h1234, 16);
    put(64'(model_crc16()), 16);
    expect_pulse(1'b0, 4'd7, 1'b1, 40, 1);
    send_frame(1'b0);
    send_eop();
    idle(6);
    check_eq("reqrn_code_held", 64'(cmd_code), 64'd7);

    // Truncated ACK
    start_frame();
    put(64'h1, 2);
    put(64'hA5, 8);
    expect_pulse(1'b1, 4'd2, 1'b0, 10, 1);
    send_frame(1'b0);
    send_eop();
    idle(3);

    // Unknown opcode 1011, trailing bits ignored
    start_frame();
    put(64'hB, 4);
    expect_pulse(1'b1, 4'd15, 1'b0, 4, 1);
    send_frame(1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b0);
    check_eq("unk_frozen_cnt", 64'(bitcount), 64'd4);
    check_eq("unk_frozen_pay", 64'(payload), 64'hB);
    send_eop();
    idle(3);

    // Restart mid-Query, then QueryRep
    start_frame();
    put(64'h8, 4);
    put(64'h0, 8);
    send_frame(1'b0);
    check_eq("mid_query_cnt", 64'(bitcount), 64'd12);
    start_frame();
    check_eq("restart_cnt", 64'(bitcount), 64'd0);
    check_eq("restart_pay", 64'(payload), 64'd0);
    check_eq("restart_code", 64'(cmd_code), 64'd0);
    put(64'h3, 4);
    expect_pulse(1'b0, 4'd1, 1'b1, 4, 1);
    send_frame(1'b0);
    send_eop();
    idle(3);

    // Select too short for an eop-terminated command
    start_frame();
    put(64'hA, 4);
    put(64'h155, 10);
    expect_pulse(1'b1, 4'd5, 1'b0, 14, 1);
    send_frame(1'b0);
    send_eop();
    idle(3);

    // Select at exactly the minimum length
    start_frame();
    put(64'hA, 4);
    put(64'h3, 4);
    put(64'(model_crc16()), 16);
    expect_pulse(1'b0, 4'd5, 1'b1, 24, 1);
    send_frame(1'b0);
    send_eop();
    idle(3);

    // Select with eop coincident on the final bit
    start_frame();
    put(64'hA, 4);
    put(64'hC3A5, 16);
    put(64'(model_crc16()), 16);
    expect_pulse(1'b0, 4'd5, 1'b1, 36, 2);
    send_frame(1'b1);
    idle(4);

    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    check_eq("sb_drain", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
